fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reorder buffer placed directly downstream of the final radix-2 stage (`fft_stage_n0`) of the FFT pipeline. It accepts one complete frame of N = 2^LOG2N complex samples in bit-reversed index order and replays the frame in natural order. It uses two ping-pong banks, so frames can stream back-to-back at one sample per clock. Its input port set matches the stage outputs exactly, and its output port set uses the same start/valid convention.

## Interface
- `DATA_WIDTH`, 16: width of each real and imaginary sample.
- `LOG2N`, 8: log2 of the FFT length. Must be at least 2.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sig_start_i`  in  1  first sample of a frame; qualified by `sig_vld_i`.
- `sig_vld_i`  in  1  input sample valid.
- `sig_real_i`  in  DATA_WIDTH  real part, two's complement.
- `sig_imag_i`  in  DATA_WIDTH  imaginary part, two's complement.
- `sig_start_o`  out  1  high only with output sample index 0.
- `sig_vld_o`  out  1  output sample valid.
- `sig_real_o`  out  DATA_WIDTH  real part of the output sample; 0 when `sig_vld_o`=0.
- `sig_imag_o`  out  DATA_WIDTH  imaginary part of the output sample; 0 when `sig_vld_o`=0.
- `frame_err_o`  out  1  sticky error flag (short frame or overflow); cleared only by reset.

## Operation
- Storage: 2 banks, each N words of 2*DATA_WIDTH bits. Write and read are independent. Data passes through unmodified, with no arithmetic and no width change.
- Write FSM, states W_IDLE and W_FILL; a write-bank pointer `wb` (reset 0) selects the bank.
  - W_IDLE: `sig_vld_i`=1 with `sig_start_i`=0 is ignored. When `sig_start_i`&`sig_vld_i`, write the sample at address bitrev(0)=0, set cnt=1, go to W_FILL.
  - W_FILL: each `sig_vld_i`=1 writes to address bitrev(cnt), then cnt++. Gaps in `sig_vld_i` are allowed.
  - When the write with cnt=N-1 completes: set full[wb], toggle `wb`, go to W_IDLE.
- Short frame: `sig_start_i`&`sig_vld_i` while in W_FILL with cnt≠0 sets `frame_err_o`. The partial frame is discarded. The current sample is written as index 0 of the same bank, and cnt=1.
- Overflow: a frame start while full[wb]=1 sets `frame_err_o`. The whole frame is dropped and the FSM stays in W_IDLE.
- Read FSM, states R_IDLE and R_READ; a read-bank pointer `rb` (reset 0) selects the bank.
  - R_IDLE: when full[rb]=1, go to R_READ with raddr=0.
  - R_READ: issue one read per cycle, raddr 0..N-1. After raddr=N-1 is issued, clear full[rb] and toggle `rb`.
  - If full[new rb] is already set at that point, continue with raddr=0 on the next cycle, with no bubble. Otherwise return to R_IDLE.
- full[0] and full[1] are set and cleared independently. A set on one bit and a clear on the other in the same edge are both honoured.
- Reset: all FSMs idle; cnt, raddr, wb, rb, full, and `frame_err_o` all cleared; all outputs 0. RAM contents are not reset. A frame in flight is lost.

## Timing
- RAM read is synchronous, one cycle. Outputs are registered.
- Latency: let the last sample of a frame be written at edge T. Then `sig_start_o`/`sig_vld_o` and sample 0 appear after edge T+2, provided the read side is idle.
- An output frame is exactly N consecutive cycles of `sig_vld_o`=1. `sig_start_o`=1 in the first of these cycles only.
- Sustained input at one sample per clock never overflows. The reader drains N samples in N cycles, and filling a bank takes at least N cycles.
- `frame_err_o` rises on the edge that samples the offending start.

## Structure
- Shared package/header `fft_pkg`:
  - constant N = 1<<LOG2N
  - the `bitrev` function (LOG2N bits)
  - write/read FSM state encodings
- One sub-module, `fft_pingpong_ram`: a simple dual-port RAM with depth 2N, width 2*DATA_WIDTH, a registered read port, and address {bank, index}.

## Test plan
All scenarios use LOG2N=3 (N=8), DATA_WIDTH=16.
- Single frame: real = 0,4,2,6,1,5,3,7 in consecutive cycles, imag = -real -> output real 0..7 with imag 0..-7. `sig_start_o` with sample 0. First output appears 2 cycles after the last input.
- Back-to-back: 4 contiguous frames (real = frame*8 + bitrev order) -> 32 contiguous output cycles in natural order, one `sig_start_o` per 8 cycles, no bubbles, `frame_err_o`=0.
- Gappy input: `sig_vld_i` toggling 1,0 across one frame -> same output as the single-frame case, emitted contiguously after the frame completes.
- Short frame: start, 3 samples, then a new start plus a full 8-sample frame -> `frame_err_o`=1, and only the second frame is output.
- Idle noise: `sig_vld_i`=1 without a prior start, and `sig_start_i`=1 with `sig_vld_i`=0 -> no writes, no output, no error.
- Reset mid-output: assert `rst_n`=0 at output sample 3 -> all outputs 0 immediately. After release, a new frame is reordered correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT output reorder slice:
//   - MAX_LOG2N / LOG2N_DEFAULT / N_DEFAULT : size constants
//   - fft_len()  : transform length for a given log2 size (N = 1 << LOG2N)
//   - bitrev()   : reverse the low log2n bits of an index
//   - wr_state_e / rd_state_e : write and read FSM state encodings
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int unsigned MAX_LOG2N     = 16;
    localparam int unsigned LOG2N_DEFAULT = 8;
    localparam int unsigned N_DEFAULT     = 32'd1 << LOG2N_DEFAULT;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_e;

    function automatic int unsigned fft_len(input int unsigned log2n);
        return 32'd1 << log2n;
    endfunction

    // Reverse all MAX_LOG2N bits, then shift the reversed field down so only
    // the low log2n bits of the original index end up reversed in place.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                    input int unsigned          log2n);
        logic [MAX_LOG2N-1:0] rev;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            rev[i] = idx[MAX_LOG2N-1-i];
        end
        return rev >> (MAX_LOG2N - log2n);
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_if
// Sample stream bundle around the bit-reversal reorder buffer.
//   sig_start_i / sig_vld_i / sig_real_i / sig_imag_i : bit-reversed frame in
//   sig_start_o / sig_vld_o / sig_real_o / sig_imag_o : natural-order frame out
//   frame_err_o : sticky short-frame / overflow flag
// Modports: slave = reorder buffer side, master = upstream/downstream side.
// ---------------------------------------------------------------------------
interface fft_bitrev_reorder_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  sig_start_i;
    logic                  sig_vld_i;
    logic [DATA_WIDTH-1:0] sig_real_i;
    logic [DATA_WIDTH-1:0] sig_imag_i;
    logic                  sig_start_o;
    logic                  sig_vld_o;
    logic [DATA_WIDTH-1:0] sig_real_o;
    logic [DATA_WIDTH-1:0] sig_imag_o;
    logic                  frame_err_o;

    modport master (
        output sig_start_i, sig_vld_i, sig_real_i, sig_imag_i,
        input  sig_start_o, sig_vld_o, sig_real_o, sig_imag_o, frame_err_o
    );

    modport slave (
        input  sig_start_i, sig_vld_i, sig_real_i, sig_imag_i,
        output sig_start_o, sig_vld_o, sig_real_o, sig_imag_o, frame_err_o
    );
endinterface

// File: rtl/fft_pingpong_ram.sv
// ---------------------------------------------------------------------------
// fft_pingpong_ram
// Simple dual-port RAM holding two frame banks, address = {bank, index}.
//   clk, rst_n     : clock, async active-low reset (read register only)
//   we/waddr/wdata : write port
//   re/raddr       : read request, data lands in rdata one cycle later
//   rdata          : registered read data
// Memory contents are not reset.
// ---------------------------------------------------------------------------
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOG2N      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [LOG2N:0]          waddr,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    input  logic                    re,
    input  logic [LOG2N:0]          raddr,
    output logic [2*DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 2 * fft_len(LOG2N);

    logic [2*DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [2*DATA_WIDTH-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {(2*DATA_WIDTH){1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Accepts one frame of N = 2^LOG2N complex samples in bit-reversed order and
// replays it in natural order through two ping-pong banks, so frames can
// stream back-to-back at one sample per clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fft_bitrev_reorder_if.slave (sample in/out, frame_err_o)
// Latency: last input sample written at edge T -> sample 0 out after T+2.
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOG2N      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_bitrev_reorder_if.slave   bus
);
    localparam int unsigned       N        = fft_len(LOG2N);
    localparam int unsigned       WW       = 2 * DATA_WIDTH;
    localparam logic [LOG2N-1:0]  LAST_IDX = LOG2N'(N - 32'd1);
    localparam logic [LOG2N-1:0]  ZERO_IDX = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0]  ONE_IDX  = LOG2N'(32'd1);

    // Bank status shared by both sides.
    logic [1:0]       full_r, full_s;
    logic             err_r;

    // Write side.
    wr_state_e        wr_state_r, wr_state_s;
    logic [LOG2N-1:0] wr_cnt_r, wr_cnt_s, wr_idx_s;
    logic             wb_r, wb_s;
    logic             we_s, full_set_s, err_set_s;

    // Read side.
    rd_state_e        rd_state_r, rd_state_s;
    logic [LOG2N-1:0] raddr_r, raddr_s, rd_idx_s;
    logic             rb_r, rb_s;
    logic             re_s, rd_first_s, full_clr_s;

    // Output pipeline.
    logic [WW-1:0]         rdata_s;
    logic                  rd_vld_r, rd_start_r;
    logic                  out_vld_r, out_start_r;
    logic [DATA_WIDTH-1:0] out_real_r, out_imag_r;

    // Write FSM next state: fill a bank, flag short frames and overflows.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_cnt_s   = wr_cnt_r;
        wb_s       = wb_r;
        wr_idx_s   = ZERO_IDX;
        we_s       = 1'b0;
        full_set_s = 1'b0;
        err_set_s  = 1'b0;
        case (wr_state_r)
            W_IDLE: begin
                if (bus.sig_vld_i && bus.sig_start_i) begin
                    if (full_r[wb_r]) begin
                        // Both banks busy: drop the whole frame.
                        err_set_s = 1'b1;
                    end else begin
                        we_s       = 1'b1;
                        wr_cnt_s   = ONE_IDX;
                        wr_state_s = W_FILL;
                    end
                end else begin
                    wr_state_s = W_IDLE;
                end
            end
            W_FILL: begin
                if (bus.sig_vld_i) begin
                    we_s = 1'b1;
                    if (bus.sig_start_i) begin
                        // Restart the bank with this sample as index 0.
                        err_set_s = 1'b1;
                        wr_cnt_s  = ONE_IDX;
                    end else begin
                        wr_idx_s = LOG2N'(bitrev(MAX_LOG2N'(wr_cnt_r), LOG2N));
                        if (wr_cnt_r == LAST_IDX) begin
                            full_set_s = 1'b1;
                            wb_s       = ~wb_r;
                            wr_cnt_s   = ZERO_IDX;
                            wr_state_s = W_IDLE;
                        end else begin
                            wr_cnt_s = wr_cnt_r + ONE_IDX;
                        end
                    end
                end else begin
                    wr_state_s = W_FILL;
                end
            end
            default: begin
                wr_state_s = W_IDLE;
                wr_cnt_s   = ZERO_IDX;
            end
        endcase
    end

    // Read FSM next state: sweep a full bank in natural order, chain banks.
    always_comb begin
        rd_state_s = rd_state_r;
        raddr_s    = raddr_r;
        rb_s       = rb_r;
        rd_idx_s   = ZERO_IDX;
        re_s       = 1'b0;
        rd_first_s = 1'b0;
        full_clr_s = 1'b0;
        case (rd_state_r)
            R_IDLE: begin
                // Index 0 is issued on the entry edge to hold the T+2 latency.
                if (full_r[rb_r]) begin
                    re_s       = 1'b1;
                    rd_first_s = 1'b1;
                    raddr_s    = ONE_IDX;
                    rd_state_s = R_READ;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_READ: begin
                re_s       = 1'b1;
                rd_idx_s   = raddr_r;
                rd_first_s = (raddr_r == ZERO_IDX);
                if (raddr_r == LAST_IDX) begin
                    full_clr_s = 1'b1;
                    rb_s       = ~rb_r;
                    raddr_s    = ZERO_IDX;
                    // A bank completing on this same edge counts too, so
                    // back-to-back frames leave no gap.
                    if (full_r[~rb_r] || (full_set_s && (wb_r != rb_r))) begin
                        rd_state_s = R_READ;
                    end else begin
                        rd_state_s = R_IDLE;
                    end
                end else begin
                    raddr_s = raddr_r + ONE_IDX;
                end
            end
            default: begin
                rd_state_s = R_IDLE;
                raddr_s    = ZERO_IDX;
            end
        endcase
    end

    // Bank full flags: set by the writer, cleared by the reader, independently.
    always_comb begin
        full_s = full_r;
        if (full_set_s) begin
            full_s[wb_r] = 1'b1;
        end else begin
            full_s[wb_r] = full_r[wb_r];
        end
        if (full_clr_s) begin
            full_s[rb_r] = 1'b0;
        end else begin
            full_s[rb_r] = full_s[rb_r];
        end
    end

    // Control state registers for both FSMs and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_r <= W_IDLE;
            wr_cnt_r   <= ZERO_IDX;
            wb_r       <= 1'b0;
            rd_state_r <= R_IDLE;
            raddr_r    <= ZERO_IDX;
            rb_r       <= 1'b0;
            full_r     <= 2'b00;
            err_r      <= 1'b0;
        end else begin
            wr_state_r <= wr_state_s;
            wr_cnt_r   <= wr_cnt_s;
            wb_r       <= wb_s;
            rd_state_r <= rd_state_s;
            raddr_r    <= raddr_s;
            rb_r       <= rb_s;
            full_r     <= full_s;
            err_r      <= err_r | err_set_s;
        end
    end

    fft_pingpong_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2N      (LOG2N)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr ({wb_r, wr_idx_s}),
        .wdata ({bus.sig_real_i, bus.sig_imag_i}),
        .re    (re_s),
        .raddr ({rb_r, rd_idx_s}),
        .rdata (rdata_s)
    );

    // Output pipeline: align flags with RAM data, zero the data when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r    <= 1'b0;
            rd_start_r  <= 1'b0;
            out_vld_r   <= 1'b0;
            out_start_r <= 1'b0;
            out_real_r  <= {DATA_WIDTH{1'b0}};
            out_imag_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rd_vld_r    <= re_s;
            rd_start_r  <= re_s & rd_first_s;
            out_vld_r   <= rd_vld_r;
            out_start_r <= rd_start_r;
            if (rd_vld_r) begin
                out_real_r <= rdata_s[WW-1:DATA_WIDTH];
                out_imag_r <= rdata_s[DATA_WIDTH-1:0];
            end else begin
                out_real_r <= {DATA_WIDTH{1'b0}};
                out_imag_r <= {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign bus.sig_start_o = out_start_r;
    assign bus.sig_vld_o   = out_vld_r;
    assign bus.sig_real_o  = out_real_r;
    assign bus.sig_imag_o  = out_imag_r;
    assign bus.frame_err_o = err_r;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Self-checking bench for fft_bitrev_reorder with N = 8, DATA_WIDTH = 16.
// A frame-level model turns each completed input frame into its natural-order
// output list; a compare process checks the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;
    localparam int DW = 16;
    localparam int LG = 3;
    localparam int N  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DATA_WIDTH(DW)) bus ();

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .LOG2N(LG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          out_pos = 0;
    bit          m_err   = 1'b0;
    logic [31:0] exp_q  [$];
    int          comp_q [$];
    logic [31:0] got_q  [$];

    function automatic int brev3(input int k);
        logic [2:0] b;
        b = k[2:0];
        return {29'd0, b[0], b[1], b[2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame model: input sample k of a frame belongs at natural index brev(k).
    initial begin : model
        logic [31:0] frame [N];
        int          m_cnt;
        bit          m_act;
        m_cnt = 0;
        m_act = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 1'b0;
                m_cnt = 0;
                m_err = 1'b0;
                exp_q.delete();
                comp_q.delete();
            end else begin
                cyc++;
                if (bus.sig_vld_i) begin
                    if (bus.sig_start_i) begin
                        if (m_act) m_err = 1'b1;
                        m_act = 1'b1;
                        m_cnt = 0;
                    end
                    if (m_act) begin
                        frame[brev3(m_cnt)] = {bus.sig_real_i, bus.sig_imag_i};
                        m_cnt++;
                        if (m_cnt == N) begin
                            for (int k = 0; k < N; k++) exp_q.push_back(frame[k]);
                            comp_q.push_back(cyc);
                            m_act = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin : compare
        logic [31:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                out_pos = 0;
                chk("rst_vld",   32'(bus.sig_vld_o),   32'd0);
                chk("rst_start", 32'(bus.sig_start_o), 32'd0);
                chk("rst_real",  32'(bus.sig_real_o),  32'd0);
                chk("rst_err",   32'(bus.frame_err_o), 32'd0);
            end else begin
                if (bus.sig_vld_o) begin
                    got_q.push_back({bus.sig_real_o, bus.sig_imag_o});
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'(bus.sig_vld_o), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_real",  32'(bus.sig_real_o),  32'(e[31:16]));
                        chk("out_imag",  32'(bus.sig_imag_o),  32'(e[15:0]));
                        chk("out_start", 32'(bus.sig_start_o), 32'(out_pos == 0));
                        if (out_pos == 0 && comp_q.size() > 0) begin
                            c = comp_q.pop_front();
                            chk("latency", 32'(cyc - c), 32'd2);
                        end
                        out_pos = (out_pos + 1) % N;
                    end
                end else begin
                    chk("idle_real",  32'(bus.sig_real_o),  32'd0);
                    chk("idle_imag",  32'(bus.sig_imag_o),  32'd0);
                    chk("idle_start", 32'(bus.sig_start_o), 32'd0);
                    if (out_pos != 0) chk("bubble", 32'(bus.sig_vld_o), 32'd1);
                end
                chk("frame_err", 32'(bus.frame_err_o), 32'(m_err));
            end
        end
    end

    task automatic send(input logic st, input logic v, input logic [15:0] re, input logic [15:0] im);
        @(posedge clk);
        #1;
        bus.sig_start_i = st;
        bus.sig_vld_i   = v;
        bus.sig_real_i  = re;
        bus.sig_imag_i  = im;
    endtask

    task automatic idle();
        send(1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic send_frame(input int base, input bit gap);
        int r;
        for (int k = 0; k < N; k++) begin
            r = base + brev3(k);
            send(k == 0, 1'b1, 16'(r), 16'(-r));
            if (gap) idle();
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && out_pos == 0 && !bus.sig_vld_o) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
        repeat (3) idle();
    endtask

    task automatic pin_frame(input int base);
        logic [15:0] ni;
        chk("frame_count", 32'(got_q.size()), 32'd8);
        if (got_q.size() == N) begin
            for (int k = 0; k < N; k++) begin
                ni = 16'(-(base + k));
                chk("pin_real", 32'(got_q[k][31:16]), 32'(base + k));
                chk("pin_imag", 32'(got_q[k][15:0]),  32'(ni));
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit found;
        bus.sig_start_i = 1'b0;
        bus.sig_vld_i   = 1'b0;
        bus.sig_real_i  = 16'd0;
        bus.sig_imag_i  = 16'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("brev_pin_1", 32'(brev3(1)), 32'd4);
        chk("brev_pin_6", 32'(brev3(6)), 32'd3);

        // Single frame.
        got_q.delete();
        send_frame(0, 1'b0);
        idle();
        drain("single_drain");
        pin_frame(0);

        // Gappy frame.
        got_q.delete();
        send_frame(0, 1'b1);
        drain("gappy_drain");
        pin_frame(0);

        // Four frames back-to-back.
        got_q.delete();
        for (int f = 0; f < 4; f++) send_frame(f * 8, 1'b0);
        idle();
        drain("b2b_drain");
        chk("b2b_count", 32'(got_q.size()), 32'd32);
        if (got_q.size() == 32) begin
            for (int k = 0; k < 32; k++) chk("b2b_real", 32'(got_q[k][31:16]), 32'(k));
        end
        chk("b2b_err", 32'(bus.frame_err_o), 32'd0);

        // Idle noise: valid without start, start without valid.
        got_q.delete();
        repeat (3) send(1'b0, 1'b1, 16'd5, 16'd5);
        repeat (2) send(1'b1, 1'b0, 16'd9, 16'd9);
        idle();
        repeat (12) idle();
        chk("noise_count", 32'(got_q.size()), 32'd0);
        chk("noise_err",   32'(bus.frame_err_o), 32'd0);

        // Short frame followed by a full frame.
        got_q.delete();
        for (int k = 0; k < 4; k++) send(k == 0, 1'b1, 16'(100 + k), 16'd0);
        send_frame(0, 1'b0);
        idle();
        drain("short_drain");
        chk("short_err", 32'(bus.frame_err_o), 32'd1);
        pin_frame(0);

        // Reset at output sample 3, then a clean frame.
        got_q.delete();
        send_frame(16, 1'b0);
        idle();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (bus.sig_vld_o && bus.sig_real_o == 16'd19) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_wait", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_imm_vld",   32'(bus.sig_vld_o),   32'd0);
        chk("rst_imm_start", 32'(bus.sig_start_o), 32'd0);
        chk("rst_imm_real",  32'(bus.sig_real_o),  32'd0);
        chk("rst_imm_imag",  32'(bus.sig_imag_o),  32'd0);
        chk("rst_imm_err",   32'(bus.frame_err_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        send_frame(40, 1'b0);
        idle();
        drain("post_rst_drain");
        pin_frame(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
